axi_wr_burst_ctrl: RTL and testbench

Master-side AXI4 write-burst sequencer for one local requester. It accepts a burst command (address, beat count, ID) and drives AW, then W, then B in strict order. An internal beat counter generates WLAST and tracks burst completion. Completion status is returned to the requester as a one-cycle done pulse. The block sits between a local write engine (e.g. a DMA or cache write-back path) and an AXI master port of the interconnect.

---
 rtl/axi_wr_burst_ctrl.sv | 159 +++++++++++++++
 tb/tb_axi_wr_burst_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_burst_ctrl.sv
// axi_wr_burst_ctrl
// AXI4 master-side write-burst sequencer for a single local requester.
// It accepts one burst command, then runs AW, W and B strictly in that order.
// A beat counter generates WLAST. Completion is reported as a one-cycle
// done_valid pulse, with the burst's BRESP held on done_resp.
//
// Optional build macro: AXI_WR_TIMEOUT_EN
//   Adds a B-response watchdog. If no BVALID arrives within TIMEOUT_CYC
//   cycles in RESP, the burst completes with done_resp = SLVERR (2'b10).
//   Without the macro, RESP waits indefinitely.
//
// Ports
//   clk, rst                     clock; asynchronous active-high reset
//   req_valid/req_ready          command handshake
//   req_addr/req_len/req_id      burst address, beats-1, AXI ID
//   wd_valid/wd_ready            local write-data beat handshake
//   wd_data/wd_strb              local write data and byte strobes
//   done_valid/done_resp         completion pulse and held BRESP
//   AW*/W*/B*                    AXI4 write channels (BID is ignored)
module axi_wr_burst_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned ID_W        = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [LEN_W-1:0]      req_len,
  input  logic [ID_W-1:0]       req_id,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_W-1:0]     wd_data,
  input  logic [DATA_W/8-1:0]   wd_strb,
  output logic                  done_valid,
  output logic [1:0]            done_resp,
  output logic [ID_W-1:0]       AWID,
  output logic [ADDR_W-1:0]     AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic [1:0]            AWBURST,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_W-1:0]     WDATA,
  output logic [DATA_W/8-1:0]   WSTRB,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [ID_W-1:0]       BID,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_len;
  logic [ID_W-1:0]     r_id;
  logic [LEN_W-1:0]    r_cnt;
  logic                r_done_valid;
  logic [1:0]          r_done_resp;
  logic                w_w_hs;
  logic                w_last;
  logic                w_timeout;
  logic                w_unused_bid;

  assign w_unused_bid = ^BID;

  assign w_w_hs = (r_state == S_DATA) && wd_valid && WREADY;
  assign w_last = (r_state == S_DATA) && (r_cnt == r_len);

`ifdef AXI_WR_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] r_wdog;

  // Held at zero outside RESP, so it always starts from zero on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog <= '0;
    end else if (r_state != S_RESP) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  // Fires in the TIMEOUT_CYC-th RESP cycle; done_valid follows one cycle later.
  assign w_timeout = (r_state == S_RESP) && !BVALID &&
                     (r_wdog == WD_W'(TIMEOUT_CYC - 1));
`else
  localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid)            w_next = S_ADDR;
      S_ADDR:  if (AWREADY)              w_next = S_DATA;
      S_DATA:  if (w_w_hs && w_last)     w_next = S_RESP;
      S_RESP:  if (BVALID || w_timeout)  w_next = S_IDLE;
      default:                           w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_len        <= '0;
      r_id         <= '0;
      r_cnt        <= '0;
      r_done_valid <= 1'b0;
      r_done_resp  <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && req_valid) begin
        r_addr <= req_addr;
        r_len  <= req_len;
        r_id   <= req_id;
      end
      if (w_w_hs) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
      r_done_valid <= (r_state == S_RESP) && (BVALID || w_timeout);
      if ((r_state == S_RESP) && BVALID) begin
        r_done_resp <= BRESP;
      end else if (w_timeout) begin
        r_done_resp <= 2'b10;
      end
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign done_valid = r_done_valid;
  assign done_resp  = r_done_resp;

  assign AWID    = r_id;
  assign AWADDR  = r_addr;
  assign AWLEN   = 8'(r_len);
  assign AWSIZE  = 3'($clog2(DATA_W / 8));
  assign AWBURST = 2'b01;
  assign AWVALID = (r_state == S_ADDR);

  assign WDATA    = wd_data;
  assign WSTRB    = wd_strb;
  assign WLAST    = w_last;
  assign WVALID   = (r_state == S_DATA) && wd_valid;
  assign wd_ready = (r_state == S_DATA) && WREADY;

  assign BREADY = (r_state == S_RESP);

endmodule

// File: tb/tb_axi_wr_burst_ctrl.sv
// Self-checking bench for axi_wr_burst_ctrl (default build, 32-bit data,
// 4-bit length). Each burst is described by its command, a queue of
// random beats and the expected response. AXI channel behaviour is
// predicted from the burst description.
module tb_axi_wr_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_len, req_id;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID, AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;

  always #5 clk = ~clk;

  axi_wr_burst_ctrl #(.ADDR_W(32), .DATA_W(32), .LEN_W(4), .ID_W(4), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .req_id(req_id),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .done_valid(done_valid), .done_resp(done_resp),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int exp_lat = -1;
  logic       exp_done = 1'b0;
  logic [1:0] exp_resp = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_addr = '0; req_len = '0; req_id = '0;
    wd_valid = 1'b0; wd_data = '0; wd_strb = '0;
    AWREADY = 1'b0; WREADY = 1'b0; BID = '0; BRESP = '0; BVALID = 1'b0;
  endtask

  // Completion pulse is expected exactly once, the cycle after the B handshake.
  task automatic sample_done();
    chk("done_valid", done_valid, exp_done);
    chk("done_resp", done_resp, exp_resp);
    if (exp_done && exp_lat >= 0) chk("latency", cyc - acc_cyc, exp_lat);
    exp_done = 1'b0;
  endtask

  task automatic idle_cycle();
    idle_inputs();
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);
    chk("idle_awvalid", AWVALID, 0);
    chk("idle_wvalid", WVALID, 0);
    chk("idle_bready", BREADY, 0);
    sample_done();
    tick();
  endtask

  // mode 0: zero-wait slave and source; 1: random stalls and stray inputs;
  // 2: WREADY low for 3 cycles on beat 2; 3: wd_valid every other cycle.
  // abort_at >= 0: assert rst once that many beats have been accepted.
  task automatic run_burst(input logic [31:0] addr, input int len, input logic [3:0] id,
                           input logic [1:0] resp, input int mode, input int abort_at);
    logic [31:0] data[$];
    logic [3:0]  strb[$];
    logic        wv, wr, hs;
    int          b, guard, stall, bwait;
    for (int i = 0; i <= len; i++) begin
      data.push_back($urandom);
      strb.push_back(4'($urandom));
    end
    // command cycle
    idle_inputs();
    req_valid = 1'b1; req_addr = addr; req_len = 4'(len); req_id = id;
    @(negedge clk);
    chk("cmd_req_ready", req_ready, 1);
    chk("cmd_awvalid", AWVALID, 0);
    sample_done();
    acc_cyc = cyc;
    tick();
    // address phase
    guard = 0;
    hs = 1'b0;
    while (!hs) begin
      req_valid = (mode == 1) ? 1'($urandom) : 1'b0;
      req_addr = $urandom; req_len = 4'($urandom); req_id = 4'($urandom);
      wd_valid = 1'($urandom); wd_data = $urandom;
      AWREADY = (mode != 1 || guard > 20) ? 1'b1 : ($urandom_range(2) != 0);
      @(negedge clk);
      chk("awvalid", AWVALID, 1);
      chk("awaddr", AWADDR, addr);
      chk("awlen", AWLEN, len);
      chk("awid", AWID, id);
      chk("awsize", AWSIZE, 2);
      chk("awburst", AWBURST, 1);
      chk("aw_wvalid", WVALID, 0);
      chk("aw_wd_ready", wd_ready, 0);
      chk("aw_req_ready", req_ready, 0);
      sample_done();
      hs = AWREADY;
      tick();
      guard++;
    end
    // data phase
    AWREADY = 1'b0;
    b = 0; guard = 0; stall = 0;
    while (b <= len && guard < 400) begin
      if (b == abort_at) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_awvalid", AWVALID, 0);
        chk("rst_wvalid", WVALID, 0);
        chk("rst_wd_ready", wd_ready, 0);
        chk("rst_wlast", WLAST, 0);
        chk("rst_bready", BREADY, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_done_resp", done_resp, 0);
        chk("rst_req_ready", req_ready, 1);
        exp_resp = 2'b00;
        exp_done = 1'b0;
        tick();
        rst = 1'b0;
        idle_inputs();
        return;
      end
      case (mode)
        1:       begin wv = 1'($urandom); wr = 1'($urandom); end
        2:       begin wv = 1'b1; wr = !(b == 1 && stall < 3); if (!wr) stall++; end
        3:       begin wv = (guard % 2 == 0); wr = 1'b1; end
        default: begin wv = 1'b1; wr = 1'b1; end
      endcase
      wd_valid = wv; WREADY = wr;
      wd_data = data[b]; wd_strb = strb[b];
      req_valid = (mode == 1) ? 1'($urandom) : 1'b0;
      req_addr = $urandom;
      AWREADY = 1'($urandom);
      @(negedge clk);
      chk("wvalid", WVALID, wv);
      chk("wd_ready", wd_ready, wr);
      chk("wlast", WLAST, (b == len));
      if (wv) begin
        chk("wdata", WDATA, data[b]);
        chk("wstrb", WSTRB, strb[b]);
      end
      chk("w_awvalid", AWVALID, 0);
      chk("w_bready", BREADY, 0);
      chk("w_req_ready", req_ready, 0);
      sample_done();
      if (wv && wr) b++;
      tick();
      guard++;
    end
    chk("beat_count", b, len + 1);
    // response phase
    bwait = (mode == 1) ? $urandom_range(3) : 0;
    for (int k = 0; k <= bwait; k++) begin
      BVALID = (k == bwait);
      BRESP = (k == bwait) ? resp : 2'($urandom);
      BID = 4'($urandom);
      wd_valid = 1'($urandom); WREADY = 1'($urandom); AWREADY = 1'($urandom);
      req_valid = (mode == 1) ? 1'($urandom) : 1'b0;
      @(negedge clk);
      chk("bready", BREADY, 1);
      chk("b_wvalid", WVALID, 0);
      chk("b_wd_ready", wd_ready, 0);
      chk("b_awvalid", AWVALID, 0);
      chk("b_req_ready", req_ready, 0);
      sample_done();
      tick();
    end
    idle_inputs();
    exp_done = 1'b1;
    exp_resp = resp;
    exp_lat = (mode == 0) ? len + 4 : -1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_awvalid", AWVALID, 0);
    chk("reset_wvalid", WVALID, 0);
    chk("reset_wd_ready", wd_ready, 0);
    chk("reset_bready", BREADY, 0);
    chk("reset_done_valid", done_valid, 0);
    chk("reset_done_resp", done_resp, 0);
    chk("reset_wlast", WLAST, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_burst(32'h0000_1000, 0, 4'd3, 2'b00, 0, -1);
    idle_cycle();
    run_burst($urandom, 3, 4'd5, 2'b00, 2, -1);
    idle_cycle();
    run_burst($urandom, 15, 4'd7, 2'b00, 3, -1);
    idle_cycle();
    run_burst($urandom, 15, 4'd8, 2'b00, 0, -1);
    idle_cycle();
    run_burst($urandom, 2, 4'd9, 2'b11, 0, -1);
    run_burst($urandom, 1, 4'd2, 2'b00, 0, -1);
    idle_cycle();
    run_burst($urandom, 1, 4'd6, 2'b01, 0, -1);
    run_burst($urandom, 7, 4'd4, 2'b00, 0, 2);
    idle_cycle();
    run_burst($urandom, 7, 4'd1, 2'b10, 0, -1);
    idle_cycle();
    for (int n = 0; n < 24; n++) begin
      run_burst($urandom, $urandom_range(15), 4'($urandom), 2'($urandom), 1, -1);
      if ($urandom_range(1) == 1) idle_cycle();
    end
    idle_cycle();
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
